ir_queue: RTL and testbench

Parametrised instruction buffer that replaces the single-entry instruction register between instruction memory and the controller FSM. It holds up to DEPTH instructions in first-in-first-out order. The fetch side pushes with a valid/ready handshake. The FSM consumes the head entry with the Id advance strobe. A synchronous Flush discards queued instructions after a branch, and a sticky error flag records protocol violations.

---
 rtl/ir_queue.sv | 79 +++++++
 tb/tb_ir_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - FIFO instruction buffer between instruction memory and controller FSM
module ir_queue #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] inData,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    input  logic             Id,
    input  logic             Flush,
    output logic [CW-1:0]    Count,
    output logic             Err
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rp_q, rp_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             push, pop;

    // Full/empty come from the occupancy counter only, so the pointers may wrap freely.
    assign inReady  = (count_q != CW'(DEPTH));
    assign outValid = (count_q != '0);
    assign outData  = outValid ? mem_q[rp_q] : '0;
    assign Count    = count_q;
    assign Err      = err_q;

    assign push = inValid & inReady & ~Flush;
    assign pop  = Id & outValid & ~Flush;

    // Next-state for pointers, occupancy and the sticky violation flag; Flush wins over all.
    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        err_d   = err_q;
        if (Flush) begin
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (push) wp_d = wp_q + PW'(1);
            if (pop)  rp_d = rp_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if ((inValid && !inReady) || (Id && !outValid)) err_d = 1'b1;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage array is written on accepted pushes only and is never cleared.
    always_ff @(posedge Clk) begin
        if (push) mem_q[wp_q] <= inData;
    end

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - scoreboard bench for ir_queue with reference queue model
module tb_ir_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [WIDTH-1:0] inData = '0;
    logic             inValid = 1'b0;
    logic             inReady;
    logic [WIDTH-1:0] outData;
    logic             outValid;
    logic             Id = 1'b0;
    logic             Flush = 1'b0;
    logic [CW-1:0]    Count;
    logic             Err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] ref_q[$];
    bit               ref_err = 1'b0;

    ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset),
        .inData(inData), .inValid(inValid), .inReady(inReady),
        .outData(outData), .outValid(outValid), .Id(Id),
        .Flush(Flush), .Count(Count), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of words plus a sticky error bit.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ref_q.delete();
            ref_err = 1'b0;
        end else if (Flush) begin
            ref_q.delete();
            ref_err = 1'b0;
        end else begin
            int sz;
            sz = ref_q.size();
            if (inValid && sz == DEPTH) ref_err = 1'b1;
            if (Id && sz == 0)          ref_err = 1'b1;
            if (Id && sz > 0)           void'(ref_q.pop_front());
            if (inValid && sz < DEPTH)  ref_q.push_back(inData);
        end
    end

    // Monitor: mid-cycle, compare every visible output with the model.
    always @(negedge Clk) begin
        if (!Reset) begin
            logic [WIDTH-1:0] head;
            head = (ref_q.size() > 0) ? ref_q[0] : '0;
            chk("count",    32'(Count),    32'(ref_q.size()));
            chk("in_ready", 32'(inReady),  32'(ref_q.size() != DEPTH));
            chk("out_valid",32'(outValid), 32'(ref_q.size() != 0));
            chk("out_data", 32'(outData),  32'(head));
            chk("err",      32'(Err),      32'(ref_err));
        end
    end

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic id, input logic fl);
        inValid = v;
        inData  = d;
        Id      = id;
        Flush   = fl;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #12 Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("rst_count", 32'(Count), 0);
        chk("rst_ready", 32'(inReady), 1);
        chk("rst_oval",  32'(outValid), 0);
        chk("rst_odata", 32'(outData), 0);
        chk("rst_err",   32'(Err), 0);

        // Single push, head visible next cycle and held while Id is low.
        step(1'b1, 16'hABCD, 1'b0, 1'b0);
        chk("t1_oval", 32'(outValid), 1);
        chk("t1_data", 32'(outData), 32'h0000ABCD);
        chk("t1_cnt",  32'(Count), 1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("t1_hold", 32'(outData), 32'h0000ABCD);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill, overflow attempt, drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
        chk("t2_cnt",   32'(Count), 4);
        chk("t2_ready", 32'(inReady), 0);
        step(1'b1, 16'h0005, 1'b0, 1'b0);
        chk("t2_err",   32'(Err), 1);
        chk("t2_cnt5",  32'(Count), 4);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_seq", 32'(outData), 32'(i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("t2_oval", 32'(outValid), 0);
        chk("t2_data", 32'(outData), 0);

        // Steady push+pop at Count=2 across pointer wrap.
        step(1'b1, 16'h0100, 1'b0, 1'b0);
        step(1'b1, 16'h0101, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("t3_seq", 32'(outData), 32'h100 + 32'(i));
            step(1'b1, WIDTH'(16'h0102 + i), 1'b1, 1'b0);
            chk("t3_cnt", 32'(Count), 2);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t3_empty", 32'(Count), 0);

        // Pop while empty with a push in the same cycle.
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("t4_cnt",  32'(Count), 1);
        chk("t4_data", 32'(outData), 32'h1234);
        chk("t4_err",  32'(Err), 1);

        // Flush beats simultaneous push and pop.
        step(1'b1, 16'h2222, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 1'b0, 1'b0);
        chk("t5_pre", 32'(Count), 3);
        step(1'b1, 16'hBEEF, 1'b1, 1'b1);
        chk("t5_cnt",   32'(Count), 0);
        chk("t5_oval",  32'(outValid), 0);
        chk("t5_ready", 32'(inReady), 1);
        chk("t5_err",   32'(Err), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("t5_noenq", 32'(Count), 0);

        // Asynchronous reset mid-cycle.
        step(1'b1, 16'h4444, 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b0, 1'b0);
        inValid = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk("t6_cnt",  32'(Count), 0);
        chk("t6_oval", 32'(outValid), 0);
        chk("t6_data", 32'(outData), 0);
        #2 Reset = 1'b0;
        @(posedge Clk);
        #1;
        step(1'b1, 16'h6666, 1'b0, 1'b0);
        chk("t6_push", 32'(outData), 32'h6666);

        // Randomised traffic against the model.
        for (int i = 0; i < 200; i++) begin
            step(($urandom % 4) != 0, WIDTH'($urandom), ($urandom % 3) != 0,
                 ($urandom % 25) == 0);
        end
        step(1'b0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
